// File: rtl/alu_seq.sv
// Handshaked ALU: ADD/SUB/SET_LOW/SET_HIGH/PASS_A in one cycle, signed MUL by radix-2 shift-add.
// Optional ALU_SAT_EN clamps overflowing ADD/SUB results to the signed range instead of wrapping.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operanda,
  input  logic [WIDTH-1:0] operandb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  output logic             flag_c
);

  localparam logic [2:0] OP_ADD      = 3'b000;
  localparam logic [2:0] OP_SUB      = 3'b001;
  localparam logic [2:0] OP_SET_LOW  = 3'b010;
  localparam logic [2:0] OP_SET_HIGH = 3'b011;
  localparam logic [2:0] OP_MUL      = 3'b100;
  localparam int         HALF        = WIDTH / 2;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t             state;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic               prod_neg;
  logic [CNT_W-1:0]   cnt;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_v;
  logic               alu_c;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] prod_s;
  logic               mul_v;

  assign in_ready = (state == IDLE);

  // Single-cycle operations, evaluated straight from the inputs while IDLE.
  always_comb begin
    sum     = {1'b0, operanda} + {1'b0, operandb};
    diff    = {1'b0, operanda} - {1'b0, operandb};
    alu_res = operanda;
    alu_v   = 1'b0;
    alu_c   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (operanda[WIDTH-1] == operandb[WIDTH-1]) &&
                  (sum[WIDTH-1] != operanda[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (operanda[WIDTH-1] != operandb[WIDTH-1]) &&
                  (diff[WIDTH-1] != operanda[WIDTH-1]);
      end
      OP_SET_LOW:  alu_res = {operanda[WIDTH-1:HALF], operandb[HALF-1:0]};
      OP_SET_HIGH: alu_res = {operandb[HALF-1:0], operanda[HALF-1:0]};
      default:     alu_res = operanda;
    endcase
`ifdef ALU_SAT_EN
    // Overflow direction always follows operand A's sign for both ADD and SUB.
    if (alu_v)
      alu_res = operanda[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end

  // WIDTH-bit unsigned magnitudes represent the most-negative value exactly.
  always_comb begin
    mag_a  = operanda[WIDTH-1] ? -operanda : operanda;
    mag_b  = operandb[WIDTH-1] ? -operandb : operandb;
    prod_s = prod_neg ? -acc : acc;
    mul_v  = !((&prod_s[2*WIDTH-1:WIDTH-1]) || !(|prod_s[2*WIDTH-1:WIDTH-1]));
  end

  // Control FSM with registered result, flags and out_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      prod_neg  <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_v    <= 1'b0;
      flag_c    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (op == OP_MUL) begin
              acc      <= '0;
              mcand    <= {{WIDTH{1'b0}}, mag_a};
              mplier   <= mag_b;
              prod_neg <= operanda[WIDTH-1] ^ operandb[WIDTH-1];
              cnt      <= CNT_W'(WIDTH);
              state    <= MUL;
            end else begin
              result    <= alu_res;
              flag_z    <= (alu_res == '0);
              flag_n    <= alu_res[WIDTH-1];
              flag_v    <= alu_v;
              flag_c    <= alu_c;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        MUL: begin
          if (cnt == '0) begin
            result    <= prod_s[WIDTH-1:0];
            flag_z    <= (prod_s[WIDTH-1:0] == '0);
            flag_n    <= prod_s[WIDTH-1];
            flag_v    <= mul_v;
            flag_c    <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            if (mplier[0])
              acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=8; expectations are hand-computed,
// with ADD/SUB overflow expectations switching on ALU_SAT_EN.
module tb_alu_seq;

  localparam int WIDTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [2:0] op = 3'b000;
  logic [7:0] operanda = 8'h00;
  logic [7:0] operandb = 8'h00;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] result;
  logic       flag_z, flag_n, flag_v, flag_c;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] fl;
    int         lat;
    string      name;
  } vec_t;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .operanda(operanda), .operandb(operandb),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result),
    .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v), .flag_c(flag_c)
  );

  always #5 clk = ~clk;

  // Drives one operation for a single cycle, then counts cycles until out_valid (bounded).
  task automatic applyStimulus(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                               output int lat);
    @(negedge clk);
    op = o; operanda = a; operandb = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({in_ready, out_valid, result, flag_z, flag_n, flag_v, flag_c} !== {1'b1, 1'b0, 8'h00, 4'b0000}) begin
      errors++;
      $display("[TB] FAIL reset: got rdy=%b vld=%b res=%h zn vc=%b%b%b%b, want rdy=1 vld=0 res=00 flags=0000",
               in_ready, out_valid, result, flag_z, flag_n, flag_v, flag_c);
    end
  endtask

  task automatic run_table(input vec_t tbl[$]);
    int lat;
    foreach (tbl[i]) begin
      applyStimulus(tbl[i].op, tbl[i].a, tbl[i].b, lat);
      checks++;
      if (lat !== tbl[i].lat) begin
        errors++;
        $display("[TB] FAIL %s latency: got %0d want %0d", tbl[i].name, lat, tbl[i].lat);
      end
      checks++;
      if ({result, flag_z, flag_n, flag_v, flag_c} !== {tbl[i].res, tbl[i].fl}) begin
        errors++;
        $display("[TB] FAIL %s: got res=%h zn vc=%b%b%b%b want res=%h zn vc=%b",
                 tbl[i].name, result, flag_z, flag_n, flag_v, flag_c, tbl[i].res, tbl[i].fl);
      end
      consume();
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
        errors++;
        $display("[TB] FAIL %s release: got rdy=%b vld=%b want rdy=1 vld=0", tbl[i].name, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_single_cycle_ops();
    vec_t tbl[$];
`ifdef ALU_SAT_EN
    tbl.push_back(vec_t'{3'b000, 8'h64, 8'h32, 8'h7F, 4'b0010, 0, "add_100_50"});
    tbl.push_back(vec_t'{3'b001, 8'h80, 8'h01, 8'h80, 4'b0110, 0, "sub_min_1"});
`else
    tbl.push_back(vec_t'{3'b000, 8'h64, 8'h32, 8'h96, 4'b0110, 0, "add_100_50"});
    tbl.push_back(vec_t'{3'b001, 8'h80, 8'h01, 8'h7F, 4'b0010, 0, "sub_min_1"});
`endif
    tbl.push_back(vec_t'{3'b000, 8'hFF, 8'h01, 8'h00, 4'b1001, 0, "add_carry"});
    tbl.push_back(vec_t'{3'b001, 8'h05, 8'h07, 8'hFE, 4'b0101, 0, "sub_5_7"});
    tbl.push_back(vec_t'{3'b001, 8'h09, 8'h09, 8'h00, 4'b1000, 0, "sub_9_9"});
    tbl.push_back(vec_t'{3'b010, 8'hA5, 8'h3C, 8'hAC, 4'b0100, 0, "set_low"});
    tbl.push_back(vec_t'{3'b011, 8'hA5, 8'h3C, 8'hC5, 4'b0100, 0, "set_high"});
    tbl.push_back(vec_t'{3'b101, 8'h5A, 8'h33, 8'h5A, 4'b0000, 0, "pass_101"});
    tbl.push_back(vec_t'{3'b111, 8'h80, 8'h7F, 8'h80, 4'b0100, 0, "pass_111"});
    run_table(tbl);
  endtask

  task automatic test_mul();
    vec_t tbl[$];
    tbl.push_back(vec_t'{3'b100, 8'hF9, 8'h09, 8'hC1, 4'b0100, 9, "mul_m7_9"});
    tbl.push_back(vec_t'{3'b100, 8'h10, 8'h10, 8'h00, 4'b1010, 9, "mul_16_16"});
    tbl.push_back(vec_t'{3'b100, 8'h80, 8'h01, 8'h80, 4'b0100, 9, "mul_min_1"});
    tbl.push_back(vec_t'{3'b100, 8'hF8, 8'hF8, 8'h40, 4'b0000, 9, "mul_m8_m8"});
    tbl.push_back(vec_t'{3'b100, 8'h80, 8'hFF, 8'h80, 4'b0110, 9, "mul_min_m1"});
    run_table(tbl);
  endtask

  // Result must stay frozen while the consumer stalls, whatever the producer does.
  task automatic test_hold();
    int lat;
    applyStimulus(3'b001, 8'h05, 8'h07, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      op = 3'(i);
      operanda = 8'(i * 37 + 1);
      operandb = 8'(i * 91 + 3);
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, result, flag_z, flag_n, flag_v, flag_c} !== {1'b0, 1'b1, 8'hFE, 4'b0101}) begin
        errors++;
        $display("[TB] FAIL hold_%0d: got rdy=%b vld=%b res=%h zn vc=%b%b%b%b want rdy=0 vld=1 res=fe flags=0101",
                 i, in_ready, out_valid, result, flag_z, flag_n, flag_v, flag_c);
      end
    end
    in_valid = 1'b0;
    consume();
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL hold_release: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_mul();
    int lat;
    @(negedge clk);
    op = 3'b100; operanda = 8'hF9; operandb = 8'h09; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({in_ready, out_valid, result, flag_z, flag_n, flag_v, flag_c} !== {1'b1, 1'b0, 8'h00, 4'b0000}) begin
      errors++;
      $display("[TB] FAIL mid_mul_reset: got rdy=%b vld=%b res=%h zn vc=%b%b%b%b want rdy=1 vld=0 res=00 flags=0000",
               in_ready, out_valid, result, flag_z, flag_n, flag_v, flag_c);
    end
    applyStimulus(3'b000, 8'h01, 8'h01, lat);
    checks++;
    if ({lat[7:0], result, flag_z, flag_n, flag_v, flag_c} !== {8'd0, 8'h02, 4'b0000}) begin
      errors++;
      $display("[TB] FAIL add_after_reset: got lat=%0d res=%h zn vc=%b%b%b%b want lat=0 res=02 flags=0000",
               lat, result, flag_z, flag_n, flag_v, flag_c);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_single_cycle_ops();
    test_mul();
    test_hold();
    test_reset_mid_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
